// File: rtl/ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------+
// | ctrl_pkg : state encodings, opcodes and decode helpers shared  |
// |            by the multi-cycle controller.  Rev 1.0             |
// +----------------------------------------------------------------+
package ctrl_pkg;

  localparam int c_STATE_W = 7;
  localparam int c_OPC_W   = 7;

  typedef enum logic [c_STATE_W-1:0] {
    S_IDLE   = 7'b0000001,
    S_FETCH  = 7'b0000010,
    S_DECODE = 7'b0000100,
    S_EX     = 7'b0001000,
    S_MEM    = 7'b0010000,
    S_WB     = 7'b0100000,
    S_TRAP   = 7'b1000000
  } state_t;

  localparam logic [c_OPC_W-1:0] c_OPC_LOAD   = 7'b0000011;
  localparam logic [c_OPC_W-1:0] c_OPC_STORE  = 7'b0100011;
  localparam logic [c_OPC_W-1:0] c_OPC_OP     = 7'b0110011;
  localparam logic [c_OPC_W-1:0] c_OPC_OPIMM  = 7'b0010011;
  localparam logic [c_OPC_W-1:0] c_OPC_LUI    = 7'b0110111;
  localparam logic [c_OPC_W-1:0] c_OPC_AUIPC  = 7'b0010111;
  localparam logic [c_OPC_W-1:0] c_OPC_JAL    = 7'b1101111;
  localparam logic [c_OPC_W-1:0] c_OPC_JALR   = 7'b1100111;
  localparam logic [c_OPC_W-1:0] c_OPC_BRANCH = 7'b1100011;

  typedef struct packed {
    logic trap;
    logic pc_write;
    logic branch;
    logic reg_write;
    logic data_we;
    logic data_req;
    logic instr_req;
  } ctrl_out_t;

  function automatic logic is_legal(logic [c_OPC_W-1:0] opc);
    case (opc)
      c_OPC_LOAD, c_OPC_STORE, c_OPC_OP, c_OPC_OPIMM, c_OPC_LUI,
      c_OPC_AUIPC, c_OPC_JAL, c_OPC_JALR, c_OPC_BRANCH: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic is_mem(logic [c_OPC_W-1:0] opc);
    return (opc == c_OPC_LOAD) || (opc == c_OPC_STORE);
  endfunction

  function automatic logic writes_reg(logic [c_OPC_W-1:0] opc);
    case (opc)
      c_OPC_LOAD, c_OPC_OP, c_OPC_OPIMM, c_OPC_LUI,
      c_OPC_AUIPC, c_OPC_JAL, c_OPC_JALR: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic takes_branch(logic [c_OPC_W-1:0] opc);
    return (opc == c_OPC_JAL) || (opc == c_OPC_JALR) || (opc == c_OPC_BRANCH);
  endfunction

  // Moore output map: computed for the state being entered so outputs are registered.
  function automatic ctrl_out_t decode_outputs(state_t s, logic [c_OPC_W-1:0] opc);
    ctrl_out_t o;
    o = '0;
    case (s)
      S_FETCH: o.instr_req = 1'b1;
      S_MEM: begin
        o.data_req = 1'b1;
        o.data_we  = (opc == c_OPC_STORE);
      end
      S_WB: begin
        o.pc_write  = 1'b1;
        o.reg_write = writes_reg(opc);
        o.branch    = takes_branch(opc);
      end
      S_TRAP:  o.trap = 1'b1;
      default: o = '0;
    endcase
    return o;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ctrl_mc_if.sv
`default_nettype none
// +----------------------------------------------------------------+
// | ctrl_mc_if : memory handshake and control strobe bundle.       |
// | Rev 1.0                                                        |
// +----------------------------------------------------------------+
interface ctrl_mc_if;
  import ctrl_pkg::*;

  logic [c_OPC_W-1:0] INSTR;
  logic               INSTR_VALID;
  logic               DATA_VALID;
  logic               INSTR_REQ;
  logic               DATA_REQ;
  logic               DATA_WRITE_ENABLE;
  logic               REG_WRITE;
  logic               BRANCH;
  logic               PC_WRITE;
  logic               TRAP;

  modport master (
    input  INSTR, INSTR_VALID, DATA_VALID,
    output INSTR_REQ, DATA_REQ, DATA_WRITE_ENABLE, REG_WRITE, BRANCH, PC_WRITE, TRAP
  );

  modport slave (
    output INSTR, INSTR_VALID, DATA_VALID,
    input  INSTR_REQ, DATA_REQ, DATA_WRITE_ENABLE, REG_WRITE, BRANCH, PC_WRITE, TRAP
  );
endinterface
`default_nettype wire

// File: rtl/ctrl_wait_cnt.sv
`default_nettype none
// +----------------------------------------------------------------+
// | ctrl_wait_cnt : saturating handshake wait counter with timeout.|
// | Rev 1.0                                                        |
// +----------------------------------------------------------------+
module ctrl_wait_cnt #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  output logic [CNT_W-1:0] count,
  output logic             timeout
);

  localparam logic [CNT_W-1:0] c_LAST = CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_MAX  = '1;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != c_MAX)) begin
      count <= count + 1'b1;
    end
  end

  // Timeout only fires while still waiting, so a same-cycle valid always wins.
  generate
    if (TIMEOUT_CYCLES == 0) begin : g_no_timeout
      assign timeout = 1'b0;
    end else begin : g_timeout
      assign timeout = enable && (count == c_LAST);
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/ctrl_mc.sv
`default_nettype none
// +----------------------------------------------------------------+
// | ctrl_mc : multi-cycle instruction sequencer with handshake     |
// |           timeout and sticky trap.  Rev 1.0                    |
// +----------------------------------------------------------------+
module ctrl_mc
  import ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 8
) (
  input  logic       CLK,
  input  logic       RES,
  ctrl_mc_if.master  bus
);

  state_t             r_state;
  logic [c_OPC_W-1:0] r_opcode;
  ctrl_out_t          r_out;

  logic             w_in_wait;
  logic             w_valid;
  logic             w_timeout;
  logic [CNT_W-1:0] w_wait_count_unused;

  assign w_in_wait = (r_state == S_FETCH) || (r_state == S_MEM);
  assign w_valid   = (r_state == S_FETCH) ? bus.INSTR_VALID : bus.DATA_VALID;

  // Held clear outside the wait states, so it reads zero on every entry.
  ctrl_wait_cnt #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .CNT_W          (CNT_W)
  ) u_wait_cnt (
    .clock   (CLK),
    .reset   (RES),
    .clear   (!w_in_wait),
    .enable  (w_in_wait && !w_valid),
    .count   (w_wait_count_unused),
    .timeout (w_timeout)
  );

  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      r_state  <= S_IDLE;
      r_opcode <= '0;
      r_out    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_state <= S_FETCH;
          r_out   <= decode_outputs(S_FETCH, r_opcode);
        end
        S_FETCH: begin
          if (bus.INSTR_VALID) begin
            r_opcode <= bus.INSTR;
            r_state  <= S_DECODE;
            r_out    <= decode_outputs(S_DECODE, bus.INSTR);
          end else if (w_timeout) begin
            r_state <= S_TRAP;
            r_out   <= decode_outputs(S_TRAP, r_opcode);
          end
        end
        S_DECODE: begin
          if (is_legal(r_opcode)) begin
            r_state <= S_EX;
            r_out   <= decode_outputs(S_EX, r_opcode);
          end else begin
            r_state <= S_TRAP;
            r_out   <= decode_outputs(S_TRAP, r_opcode);
          end
        end
        S_EX: begin
          if (is_mem(r_opcode)) begin
            r_state <= S_MEM;
            r_out   <= decode_outputs(S_MEM, r_opcode);
          end else begin
            r_state <= S_WB;
            r_out   <= decode_outputs(S_WB, r_opcode);
          end
        end
        S_MEM: begin
          if (bus.DATA_VALID) begin
            r_state <= S_WB;
            r_out   <= decode_outputs(S_WB, r_opcode);
          end else if (w_timeout) begin
            r_state <= S_TRAP;
            r_out   <= decode_outputs(S_TRAP, r_opcode);
          end
        end
        S_WB: begin
          r_state <= S_FETCH;
          r_out   <= decode_outputs(S_FETCH, r_opcode);
        end
        S_TRAP: begin
          r_state <= S_TRAP;
          r_out   <= decode_outputs(S_TRAP, r_opcode);
        end
        default: begin
          r_state <= S_IDLE;
          r_out   <= '0;
        end
      endcase
    end
  end

  assign bus.INSTR_REQ         = r_out.instr_req;
  assign bus.DATA_REQ          = r_out.data_req;
  assign bus.DATA_WRITE_ENABLE = r_out.data_we;
  assign bus.REG_WRITE         = r_out.reg_write;
  assign bus.BRANCH            = r_out.branch;
  assign bus.PC_WRITE          = r_out.pc_write;
  assign bus.TRAP              = r_out.trap;

endmodule
`default_nettype wire
